adc_scan_ctrl: RTL

- Upstream controller for the Gowin GW5A ADC macro (`Gowin_ADC`).
- Generates:
  - the ADC clock;
  - the conversion request;
  - per-channel `vsenctl` codes and one-hot `TLVDS_IBUF_ADC` ADCEN enables.
- It then captures `adcvalue` when `adcrdy` rises.
- Channels are scanned round-robin. Each finished channel is emitted as a tagged sample (optionally averaged) with a one-cycle valid strobe. Downstream logic and GAO take these samples instead of raw `adcrdy`-clocked registers.

---
 rtl/adc_scan_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for the Gowin GW5A ADC macro: ADC clock, request, channel select, tagged samples.
// Define ADC_SCAN_AVG_EN to emit the mean of 2^AVG_LOG2 conversions per sample instead of the raw value.
module adc_scan_ctrl #(
  parameter int MODE           = 1,
  parameter int NUM_CH         = 2,
  parameter int CLK_DIV        = 32,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  output logic        o_adc_clk,
  output logic        o_adc_req,
  output logic [2:0]  o_vsenctl,
  output logic [4:0]  o_adcen_sel,
  input  logic        i_adc_rdy,
  input  logic [13:0] i_adc_value,
  output logic        o_sample_valid,
  output logic [2:0]  o_sample_ch,
  output logic [13:0] o_sample_value,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] CH0_CODE = (MODE == 2) ? 3'b010 : 3'b000;

  if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || CLK_DIV < 2 || NUM_CH < 1 ||
      NUM_CH > ((MODE == 2) ? 5 : 2)) begin : g_param_check
    $error("adc_scan_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_REQ, S_ACC, S_EMIT, S_NEXT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic               r_adc_clk;
  logic               r_rdy_s1;
  logic               r_rdy_s2;
  logic               r_rdy_d;
  logic               w_rdy_rise;
  logic [2:0]         r_ch;
  logic [2:0]         r_vsenctl;
  logic [4:0]         r_adcen;
  logic [SET_W-1:0]   r_settle;
  logic [TO_W-1:0]    r_to;
  logic               w_to_hit;
  logic [13:0]        r_value;
  logic               w_avg_done;
  logic [13:0]        w_emit_value;
  logic               r_valid;
  logic               r_timeout;
  logic [2:0]         r_sample_ch;
  logic [13:0]        r_sample_value;

  // Free-running ADC clock divider, independent of the scan state.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div     <= '0;
      r_adc_clk <= 1'b0;
    end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
      r_div     <= '0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // adcrdy is asynchronous: two-flop synchronizer, then a rising-edge detect.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
      r_rdy_d  <= 1'b0;
    end else begin
      r_rdy_s1 <= i_adc_rdy;
      r_rdy_s2 <= r_rdy_s1;
      r_rdy_d  <= r_rdy_s2;
    end
  end

  assign w_rdy_rise = r_rdy_s2 & ~r_rdy_d;
  assign w_to_hit   = (r_to == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef ADC_SCAN_AVG_EN
  logic [17:0] r_acc;
  logic [4:0]  r_cnt;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_SELECT) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_ACC) begin
      r_acc <= r_acc + {4'b0000, r_value};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_avg_done   = ((r_cnt + 5'd1) == 5'(1 << AVG_LOG2));
  assign w_emit_value = 14'(r_acc >> AVG_LOG2);
`else
  assign w_avg_done   = 1'b1;
  assign w_emit_value = r_value;
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_enable) w_state_nxt = S_SELECT;
      S_SELECT: w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == '0) w_state_nxt = S_REQ;
      S_REQ: begin
        // A conversion arriving on the last allowed cycle still wins over timeout.
        if (w_rdy_rise)    w_state_nxt = S_ACC;
        else if (w_to_hit) w_state_nxt = S_NEXT;
      end
      S_ACC:    w_state_nxt = w_avg_done ? S_EMIT : S_REQ;
      S_EMIT:   w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = i_enable ? S_SELECT : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ch           <= '0;
      r_vsenctl      <= CH0_CODE;
      r_adcen        <= '0;
      r_settle       <= '0;
      r_to           <= '0;
      r_value        <= '0;
      r_valid        <= 1'b0;
      r_timeout      <= 1'b0;
      r_sample_ch    <= '0;
      r_sample_value <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: r_ch <= '0;
        S_SELECT: begin
          if (MODE == 2) begin
            r_vsenctl <= 3'b010;
            r_adcen   <= 5'b00001 << r_ch;
          end else begin
            r_vsenctl <= {2'b00, r_ch[0]};
            r_adcen   <= '0;
          end
          r_settle <= SET_W'(SETTLE_CYCLES);
          r_to     <= '0;
        end
        S_SETTLE: if (r_settle != '0) r_settle <= r_settle - 1'b1;
        S_REQ: begin
          r_to <= r_to + 1'b1;
          if (w_rdy_rise)    r_value   <= i_adc_value;
          else if (w_to_hit) r_timeout <= 1'b1;
        end
        S_ACC: r_to <= '0;
        S_EMIT: begin
          r_valid        <= 1'b1;
          r_sample_ch    <= r_ch;
          r_sample_value <= w_emit_value;
        end
        S_NEXT: r_ch <= (r_ch == 3'(NUM_CH - 1)) ? 3'd0 : r_ch + 1'b1;
        default: ;
      endcase
    end
  end

  // Request is a pure state decode so an async reset drops it immediately.
  assign o_adc_req      = (r_state == S_REQ);
  assign o_busy         = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;
  assign o_adc_clk      = r_adc_clk;
  assign o_vsenctl      = r_vsenctl;
  assign o_adcen_sel    = r_adcen;
  assign o_sample_valid = r_valid;
  assign o_sample_ch    = r_sample_ch;
  assign o_sample_value = r_sample_value;
  assign o_timeout      = r_timeout;

endmodule
